// File: rtl/zfifo_rd.sv
// rtl/zfifo_rd.sv - bus-readable FIFO responder: PL pushes words, PS pops one per read of MYADDR.
// Define ZFIFO_RD_OVFCNT_EN to add a saturating dropped-push counter readable at MYADDR+2.
module zfifo_rd #(
    parameter logic [15:0] MYADDR     = 16'h0010,
    parameter int          W          = 16,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bwr,
    input  logic          bstrobe,
    input  logic [15:0]   baddr,
    input  logic [15:0]   bwrdata,
    output logic [15:0]   obus,
    input  logic          push_valid,
    input  logic [W-1:0]  push_data,
    output logic          push_ready
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [15:0] STAT_ADDR = MYADDR + 16'd1;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rp;
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  ovf;
    logic                  udf;

    logic full;
    logic empty;
    logic sel_data;
    logic sel_stat;
    logic pop_req;
    logic pop_ok;
    logic stat_wr;
    logic flush;
    logic clear;
    logic push_ok;
    logic push_drop;

    logic [15:0] data_word;
    logic [15:0] stat_word;
    logic [15:0] obus_drv;
    logic        obus_en;
    logic        unused_bits;

    assign full  = (cnt == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (cnt == '0);

    assign sel_data = (baddr == MYADDR);
    assign sel_stat = (baddr == STAT_ADDR);

    // Only the strobe cycle acts, so a two-cycle bwr still yields one action.
    assign pop_req = bstrobe && !bwr && sel_data;
    assign pop_ok  = pop_req && !empty;
    assign stat_wr = bstrobe && bwr && sel_stat;
    assign flush   = stat_wr && bwrdata[0];
    assign clear   = stat_wr && bwrdata[1];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push_valid && !flush && (!full || pop_ok);
    assign push_drop = push_valid && !flush && full && !pop_ok;

    assign push_ready  = !full;
    assign unused_bits = &{1'b0, bwrdata[15:2]};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + 1'b1;
            end
            if (pop_ok) begin
                rp <= rp + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (clear) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push_drop) begin
                ovf <= 1'b1;
            end
            if (pop_req && empty) begin
                udf <= 1'b1;
            end
        end
    end

`ifdef ZFIFO_RD_OVFCNT_EN
    localparam logic [15:0] CNT_ADDR = MYADDR + 16'd2;

    logic [15:0] ovf_cnt;
    logic        sel_cnt;

    assign sel_cnt = (baddr == CNT_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (clear) begin
            ovf_cnt <= '0;
        end else if (push_drop && (ovf_cnt != 16'hffff)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        data_word = '0;
        if (!empty) begin
            data_word[W-1:0] = mem[rp];
        end
    end

    always_comb begin
        stat_word      = '0;
        stat_word[15]  = full;
        stat_word[14]  = empty;
        stat_word[13]  = ovf;
        stat_word[12]  = udf;
        stat_word[8:0] = 9'(cnt);
    end

    always_comb begin
        obus_drv = '0;
        obus_en  = 1'b0;
        if (sel_data) begin
            obus_drv = data_word;
            obus_en  = 1'b1;
        end else if (sel_stat) begin
            obus_drv = stat_word;
            obus_en  = 1'b1;
        end
`ifdef ZFIFO_RD_OVFCNT_EN
        else if (sel_cnt) begin
            obus_drv = ovf_cnt;
            obus_en  = 1'b1;
        end
`endif
    end

    assign obus = obus_en ? obus_drv : 16'hzzzz;

endmodule

// File: tb/tb_zfifo_rd.sv
// tb/tb_zfifo_rd.sv - scoreboard bench for zfifo_rd with a queue-based reference model.
module tb_zfifo_rd;

    localparam logic [15:0] MYADDR = 16'h0010;
    localparam logic [15:0] STAT   = 16'h0011;
    localparam logic [15:0] CNTA   = 16'h0012;
    localparam int          DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        bwr = 1'b0;
    logic        bstrobe = 1'b0;
    logic [15:0] baddr = '0;
    logic [15:0] bwrdata = '0;
    wire  [15:0] obus;
    logic        push_valid = 1'b0;
    logic [15:0] push_data = '0;
    logic        push_ready;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];
    logic [15:0] m_q[$];
    logic        m_ovf;
    logic        m_udf;
    logic [15:0] m_ocnt;
    logic        m_flush;
    logic        m_clear;
    logic        m_pop;

    zfifo_rd #(.MYADDR(MYADDR), .W(16), .DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bwr        (bwr),
        .bstrobe    (bstrobe),
        .baddr      (baddr),
        .bwrdata    (bwrdata),
        .obus       (obus),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO is a plain queue; a pop is applied before the push of the same cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_ocnt = '0;
        end else begin
            m_flush = bstrobe && bwr && (baddr == STAT) && bwrdata[0];
            m_clear = bstrobe && bwr && (baddr == STAT) && bwrdata[1];
            m_pop   = bstrobe && !bwr && (baddr == MYADDR);
            if (m_flush) begin
                m_q.delete();
            end else begin
                if (m_pop) begin
                    if (m_q.size() > 0) void'(m_q.pop_front());
                    else m_udf = 1'b1;
                end
                if (push_valid) begin
                    if (m_q.size() < DEPTH) m_q.push_back(push_data);
                    else begin
                        m_ovf = 1'b1;
                        if (m_ocnt != 16'hffff) m_ocnt = m_ocnt + 16'd1;
                    end
                end
            end
            if (m_clear) begin
                m_ovf  = 1'b0;
                m_udf  = 1'b0;
                m_ocnt = '0;
            end
        end
    end

    function automatic logic [15:0] model_read(input logic [15:0] a);
        logic [15:0] r;
        r = 16'hzzzz;
        if (a == MYADDR) r = (m_q.size() == 0) ? 16'h0000 : m_q[0];
        else if (a == STAT)
            r = {m_q.size() == DEPTH, m_q.size() == 0, m_ovf, m_udf, 3'b000, 9'(m_q.size())};
`ifdef ZFIFO_RD_OVFCNT_EN
        else if (a == CNTA) r = m_ocnt;
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        logic [15:0] e;
        if (bstrobe && !bwr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: read of %h with no expected value", baddr);
            end else begin
                e = exp_q.pop_front();
                if (obus !== e) begin
                    n_fail++;
                    $display("FAIL obus@%h: got %h expected %h", baddr, obus, e);
                end
            end
        end
        n_checks++;
        if (push_ready !== (m_q.size() < DEPTH)) begin
            n_fail++;
            $display("FAIL push_ready: got %b expected %b", push_ready, m_q.size() < DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] e);
        baddr   = a;
        bwr     = 1'b0;
        bstrobe = 1'b1;
        exp_q.push_back(e);
        tick();
        bstrobe = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d,
                             input logic pf, input logic [15:0] pd);
        baddr   = a;
        bwrdata = d;
        bwr     = 1'b1;
        bstrobe = 1'b0;
        tick();
        bstrobe    = 1'b1;
        push_valid = pf;
        push_data  = pd;
        tick();
        bstrobe    = 1'b0;
        bwr        = 1'b0;
        push_valid = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d);
        push_valid = 1'b1;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            push_word(16'h0100 + 16'(i));
            if (i == 14) check1("ready_before_full", push_ready, 1'b1);
            if (i == 15) check1("ready_after_full", push_ready, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] z16;
        z16 = 16'hzzzz;
        #1 rst_n = 1'b0;
        tick();
        bus_read(STAT, 16'h4000);
        tick();
        rst_n = 1'b1;
        tick();

        bus_read(STAT, 16'h4000);
        bus_read(MYADDR, 16'h0000);
        bus_read(STAT, 16'h5000);
        bus_write(STAT, 16'h0002, 1'b0, '0);
        bus_read(STAT, 16'h4000);
        bus_read(16'h0013, z16);

        fill16();
        bus_read(STAT, 16'h8010);
        push_valid = 1'b1;
        push_data  = 16'hdead;
        repeat (3) tick();
        push_valid = 1'b0;
        bus_read(STAT, 16'hA010);
`ifdef ZFIFO_RD_OVFCNT_EN
        bus_read(CNTA, 16'h0003);
`else
        bus_read(CNTA, z16);
`endif
        bus_write(STAT, 16'h0002, 1'b0, '0);
        bus_read(STAT, 16'h8010);
`ifdef ZFIFO_RD_OVFCNT_EN
        bus_read(CNTA, 16'h0000);
`else
        bus_read(CNTA, z16);
`endif
        bus_write(MYADDR, 16'hffff, 1'b0, '0);
        bus_read(STAT, 16'h8010);

        push_valid = 1'b1;
        push_data  = 16'h0110;
        bus_read(MYADDR, 16'h0100);
        push_valid = 1'b0;
        bus_read(STAT, 16'h8010);
        for (int i = 1; i <= 16; i++) bus_read(MYADDR, 16'h0100 + 16'(i));
        bus_read(STAT, 16'h4000);

        for (int i = 0; i < 5; i++) push_word(16'h0200 + 16'(i));
        bus_write(STAT, 16'h0001, 1'b1, 16'h0299);
        bus_read(STAT, 16'h4000);
        bus_read(MYADDR, 16'h0000);
        bus_read(STAT, 16'h5000);
        bus_write(STAT, 16'h0002, 1'b0, '0);

        for (int i = 0; i < 3; i++) push_word(16'h0300 + 16'(i));
        baddr = MYADDR;
        bwr   = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bus_read(STAT, 16'h4000);
        check1("ready_after_reset", push_ready, 1'b1);
        bus_read(MYADDR, 16'h0000);
        bus_write(STAT, 16'h0002, 1'b0, '0);

        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            push_valid = ($urandom_range(0, 99) < 55);
            push_data  = 16'($urandom);
            if (r < 7) bus_read(MYADDR, model_read(MYADDR));
            else if (r < 10) bus_read(STAT, model_read(STAT));
            else if (r == 10) bus_read(CNTA, model_read(CNTA));
            else if (r == 11) begin
                push_valid = 1'b0;
                bus_write(STAT, {14'b0, 1'($urandom), 1'b1}, 1'($urandom), 16'($urandom));
            end else tick();
        end
        push_valid = 1'b0;
        tick();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected reads never observed", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
